stack_ctrl256: RTL and testbench
================================

# stack_ctrl256

Hardware stack controller that owns the address, write-data and write-enable ports of the 256 x 16-bit storage array and presents a push/pop/dump interface to the datapath. It keeps the stack pointer and occupancy count, drives the storage ports each cycle, and registers popped data with a one-cycle valid strobe. It detects overflow and underflow, and can drain the whole stack one word per cycle.

## Interface
Parameters: none.

- CLK  input  1  single clock; all state updates on rising edge
- reset  input  1  one clock; reset is synchronous and active-low
- push  input  1  push pushData this cycle
- pop  input  1  pop top entry this cycle
- dump  input  1  start drain of all entries, top first
- clrErr  input  1  clear sticky error (STACK_ERR_EN only)
- pushData  input  16  word to push
- popData  output  16  registered popped word
- popValid  output  1  popData valid, one-cycle pulse
- busy  output  1  high while in DUMP
- full  output  1  count == 256
- empty  output  1  count == 0
- count  output  9  occupancy, 0..256
- error  output  1  sticky overflow/underflow flag
- mem_address  output  8  storage address
- mem_writeData  output  16  storage write data, equals pushData
- mem_write  output  1  storage write enable
- mem_readData  input  16  storage asynchronous read data

## Operation
- State: count[8:0]. sp = count[7:0] is the next free slot, and sp-1 (mod 256) is the top.
- FSM states: IDLE, DUMP. dump in IDLE with count != 0 goes to DUMP. dump with count == 0 is ignored and is not an error.
- IDLE decode, evaluated in priority order:
  - push & pop & !empty: replace. mem_address = sp-1, mem_write = 1. popData <= mem_readData (the old top). count unchanged.
  - push & pop & empty: push only, at address 0. The pop is counted as an underflow error.
  - push & !full: mem_address = sp, mem_write = 1, count+1.
  - push & full: ignored, overflow error.
  - pop & !empty: mem_address = sp-1, popData <= mem_readData, count-1.
  - pop & empty: ignored, underflow error.
  - otherwise: mem_address = sp-1, mem_write = 0.
- dump has priority over push and pop in the same cycle. Those push and pop requests are discarded without error.
- DUMP state:
  - Each cycle: mem_address = sp-1, popData <= mem_readData, count-1, mem_write = 0.
  - Return to IDLE on the cycle count goes 1 -> 0.
  - push, pop and dump are ignored while busy, with no error.
- mem_write is never asserted except as listed above.
- Storage contents are not cleared by this block. Only the pointer resets.

## Timing
- Reset (reset == 0 at a rising edge) forces:
  - state IDLE, count 0, popData 0, popValid 0, error 0
  - as a result: busy 0, full 0, empty 1
- Reset mid-DUMP aborts the drain immediately. No further popValid pulses follow.
- Pop latency: pop sampled at edge N gives popData/popValid valid after edge N, i.e. during cycle N+1. popValid is high for exactly one cycle per accepted pop.
- Push is written at the edge that samples it. The pushed word is readable as top in the next cycle.
- DUMP of k entries:
  - busy is high for k cycles, starting the cycle after dump is sampled.
  - popValid is high for k consecutive cycles, lagging busy by one cycle.
- mem_address and mem_write are combinational from state and inputs, so they are valid in the same cycle as the request.
- full, empty and count are decoded from registered count.

## Configuration
- STACK_ERR_EN defined:
  - error is set at the edge following any overflow or underflow event and holds until clrErr or reset.
  - clrErr has priority over a simultaneous new event.
- STACK_ERR_EN undefined:
  - error is tied to 0 and clrErr is unused.
  - Illegal operations are still ignored exactly as above.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop 3 times -> popData 0x3333, 0x2222, 0x1111, each with a one-cycle popValid; count 3 -> 0; empty = 1.
- Push 256 words (value = index) -> full = 1, count = 256. A 257th push -> count stays 256, mem_write = 0, error = 1 (with STACK_ERR_EN).
- With count = 2 and top = 0xAAAA, assert push 0xBBBB and pop together -> popData 0xAAAA, count 2, next pop returns 0xBBBB.
- Pop on empty -> popValid stays 0, count 0, error = 1. clrErr -> error = 0. Without STACK_ERR_EN, error stays 0 throughout.
- Push 0x0001..0x0004, then dump -> busy for 4 cycles, popValid for 4 consecutive cycles carrying 0x0004, 0x0003, 0x0002, 0x0001, then empty. push and pop during busy are ignored.
- Assert reset for one cycle during the 2nd cycle of a 4-entry dump -> next cycle count 0, busy 0, popValid 0, popData 0.

Source files
------------

// File: rtl/stack_ctrl256.sv
// 256 x 16 stack controller: push/pop/replace/dump front end for an external async-read array.
// Optional sticky overflow/underflow flag enabled with `define STACK_ERR_EN.
module stack_ctrl256 (
    input  logic        CLK,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        dump,
    input  logic        clrErr,
    input  logic [15:0] pushData,
    output logic [15:0] popData,
    output logic        popValid,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic [8:0]  count,
    output logic        error,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_writeData,
    output logic        mem_write,
    input  logic [15:0] mem_readData
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned DEPTH  = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   pop_data_q;
    logic                pop_valid_q;
    logic                pop_load;
    logic                err_evt;
    logic                full_w;
    logic                empty_w;
    logic [ADDR_W-1:0]   sp;
    logic [ADDR_W-1:0]   top;

    assign sp      = count_q[ADDR_W-1:0];
    assign top     = sp - ADDR_W'(1);
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == CNT_W'(0));

    // Request decode: next count/state, storage port drive and pop capture
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_address = top;
        mem_write   = 1'b0;
        pop_load    = 1'b0;
        err_evt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump && !empty_w) begin
                    state_d = ST_DUMP;
                end else if (push && pop && !empty_w) begin
                    mem_write = 1'b1;
                    pop_load  = 1'b1;
                end else if (push && pop) begin
                    // Empty stack: the push still lands at slot 0, the pop underflows
                    mem_address = sp;
                    mem_write   = 1'b1;
                    count_d     = count_q + CNT_W'(1);
                    err_evt     = 1'b1;
                end else if (push && !full_w) begin
                    mem_address = sp;
                    mem_write   = 1'b1;
                    count_d     = count_q + CNT_W'(1);
                end else if (push) begin
                    err_evt = 1'b1;
                end else if (pop && !empty_w) begin
                    pop_load = 1'b1;
                    count_d  = count_q - CNT_W'(1);
                end else if (pop) begin
                    err_evt = 1'b1;
                end
            end
            ST_DUMP: begin
                if (!empty_w) begin
                    pop_load = 1'b1;
                    count_d  = count_q - CNT_W'(1);
                end
                if (count_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pop_valid_q <= pop_load;
            if (pop_load) begin
                pop_data_q <= mem_readData;
            end
        end
    end

`ifdef STACK_ERR_EN
    logic err_q;

    // Sticky error; clear wins over a coincident new event
    always_ff @(posedge CLK) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (clrErr) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    logic unused_err;
    assign unused_err = &{1'b0, clrErr, err_evt};
    assign error      = 1'b0;
`endif

    assign popData       = pop_data_q;
    assign popValid      = pop_valid_q;
    assign busy          = (state_q == ST_DUMP);
    assign full          = full_w;
    assign empty         = empty_w;
    assign count         = count_q;
    assign mem_writeData = pushData;

endmodule

// File: tb/tb_stack_ctrl256.sv
// Scoreboard bench for stack_ctrl256: queue-based stack model, external storage model,
// directed test-plan sequences followed by randomized traffic.
module tb_stack_ctrl256;

`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset, push, pop, dump, clrErr;
    logic [15:0] pushData;
    logic [15:0] popData;
    logic        popValid, busy, full, empty, error;
    logic [8:0]  count;
    logic [7:0]  mem_address;
    logic [15:0] mem_writeData, mem_readData;
    logic        mem_write;

    always #5 CLK = ~CLK;

    stack_ctrl256 dut (
        .CLK(CLK), .reset(reset), .push(push), .pop(pop), .dump(dump), .clrErr(clrErr),
        .pushData(pushData), .popData(popData), .popValid(popValid), .busy(busy),
        .full(full), .empty(empty), .count(count), .error(error),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_write(mem_write), .mem_readData(mem_readData)
    );

    // External storage: synchronous write, asynchronous read
    logic [15:0] mem [256];
    always @(posedge CLK) if (mem_write) mem[mem_address] <= mem_writeData;
    assign mem_readData = mem[mem_address];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] stk[$];
    bit          in_dump = 1'b0;
    bit          m_err   = 1'b0;
    bit          mon_en  = 1'b0;
    int          tests   = 0;
    int          fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_pop(input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        expq.push_back(e);
    endtask

    task automatic check_status();
        int n;
        n = stk.size();
        chk("count", 32'(count), 32'(n));
        chk("full",  32'(full),  32'(n == 256));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("busy",  32'(busy),  32'(in_dump));
        chk("error", 32'(error), 32'(m_err));
    endtask

    // One cycle: check registered status, apply request, advance the model, check storage port
    task automatic step(input bit p, input bit q, input bit d, input bit c, input logic [15:0] v);
        bit         ew, av, evt;
        logic [7:0] ea;
        int         n;
        @(negedge CLK);
        check_status();
        push = p; pop = q; dump = d; clrErr = c; pushData = v;
        n   = stk.size();
        ew  = 1'b0;
        av  = 1'b1;
        evt = 1'b0;
        ea  = 8'(n - 1);
        if (in_dump) begin
            expect_pop(stk.pop_back());
            if (stk.size() == 0) in_dump = 1'b0;
        end else if (d && n > 0) begin
            in_dump = 1'b1;
            av = 1'b0;
        end else if (p && q && n > 0) begin
            expect_pop(stk[n-1]);
            stk[n-1] = v;
            ew = 1'b1;
        end else if (p && q) begin
            stk.push_back(v);
            ew = 1'b1; ea = 8'd0; evt = 1'b1;
        end else if (p && n < 256) begin
            stk.push_back(v);
            ew = 1'b1; ea = 8'(n);
        end else if (p) begin
            evt = 1'b1; av = 1'b0;
        end else if (q && n > 0) begin
            expect_pop(stk.pop_back());
        end else if (q) begin
            evt = 1'b1; av = 1'b0;
        end
        if (c) m_err = 1'b0;
        else if (evt) m_err = ERR_EN;
        #1;
        chk("mem_write", 32'(mem_write), 32'(ew));
        if (av) chk("mem_address", 32'(mem_address), 32'(ea));
        if (ew) chk("mem_writeData", 32'(mem_writeData), 32'(v));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        reset = 1'b0; push = 1'b0; pop = 1'b0; dump = 1'b0; clrErr = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        expq.delete();
        stk.delete();
        in_dump = 1'b0;
        m_err   = 1'b0;
        reset   = 1'b1;
        @(negedge CLK);
        chk("reset_popData",  32'(popData),  32'h0);
        chk("reset_popValid", 32'(popValid), 32'h0);
        check_status();
    endtask

    // Monitor: popValid must appear exactly when the model scheduled a popped word
    always @(negedge CLK) begin
        if (mon_en) begin
            bit ev;
            ev = (expq.size() > 0) && (expq[0].due == cyc);
            chk("popValid", 32'(popValid), 32'(ev));
            if (ev) begin
                chk("popData", 32'(popData), 32'(expq[0].data));
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; dump = 1'b0; clrErr = 1'b0; pushData = 16'h0;
        do_reset(2);
        mon_en = 1'b1;

        // LIFO order
        step(1, 0, 0, 0, 16'h1111);
        step(1, 0, 0, 0, 16'h2222);
        step(1, 0, 0, 0, 16'h3333);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        idle(2);

        // Fill to full, then overflow
        for (int i = 0; i < 256; i++) step(1, 0, 0, 0, 16'(i));
        step(1, 0, 0, 0, 16'hDEAD);
        idle(1);
        step(0, 0, 0, 1, 16'h0);
        // Replace at full is legal
        step(1, 1, 0, 0, 16'hCAFE);
        step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 256; i++) step(1, 1, 1, 0, 16'(i + 100));
        idle(2);

        // Replace with count 2
        step(1, 0, 0, 0, 16'h1234);
        step(1, 0, 0, 0, 16'hAAAA);
        step(1, 1, 0, 0, 16'hBBBB);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        idle(1);

        // Underflow, clear, push+pop on empty
        step(0, 1, 0, 0, 16'h0);
        idle(1);
        step(0, 0, 0, 1, 16'h0);
        step(1, 1, 0, 0, 16'h5A5A);
        idle(1);
        step(0, 0, 0, 1, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        idle(1);

        // Four-entry dump with ignored requests while busy
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 16'(i));
        step(0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 0, 16'hEEEE);
        step(0, 1, 0, 0, 16'h0);
        step(1, 1, 1, 0, 16'hFFFF);
        step(0, 1, 0, 0, 16'h0);
        idle(2);

        // Dump on empty is a no-op
        step(0, 0, 1, 0, 16'h0);
        idle(2);

        // Reset during the second dump cycle
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 16'(16'h40 + i));
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        do_reset(1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit p, q, d, c;
            r = int'($urandom_range(0, 99));
            p = (r < 35) || (r >= 65 && r < 80);
            q = (r >= 35 && r < 80);
            d = (r >= 80 && r < 83);
            c = ($urandom_range(0, 19) == 0);
            if (d && stk.size() == 0) begin
                p = 1'b0;
                q = 1'b0;
            end
            step(p, q, d, c, 16'($urandom));
        end
        idle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
